// File: rtl/sprite_pkg.sv
// Shared constants, item field layout and FSM encoding for the sprite line prefetcher.
package sprite_pkg;

    // Source sprite geometry and screen upscaling
    localparam int TILE_PX        = 8;
    localparam int UPSCALE        = 5;
    localparam int TILE_LEN_PIXEL = TILE_PX * UPSCALE;

    // Item word layout: [13:10] ID, [9:8] orientation, [7:0] tile
    localparam int         ITEM_W        = 14;
    localparam int         ITEM_ID_LSB   = 10;
    localparam int         ITEM_DIR_LSB  = 8;
    localparam int         ITEM_TILE_LSB = 0;
    localparam logic [3:0] ITEM_UNUSED   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_REQ   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Tile column/row that a screen coordinate falls into (constant divide by 40)
    function automatic logic [3:0] tile_of_pos(input logic [9:0] pos);
        return 4'(pos / 10'(TILE_LEN_PIXEL));
    endfunction

    // Source pixel (or source row) inside a tile for a screen coordinate
    function automatic logic [2:0] src_col_of_pos(input logic [9:0] pos);
        return 3'((pos % 10'(TILE_LEN_PIXEL)) / 10'(UPSCALE));
    endfunction

endpackage

// File: rtl/sprite_line_bank.sv
// Double-buffered tile line store: the scan fills the back bank while the
// front bank is read out; a swap exchanges the two roles.
module sprite_line_bank
    import sprite_pkg::*;
#(
    parameter int TILES_H = 16,
    parameter int IDX_W   = $clog2(TILES_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               swap,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TILE_PX-1:0] wr_data,
    input  logic [IDX_W-1:0]   chk_idx,
    output logic               chk_valid,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TILE_PX-1:0] rd_data
);

    logic               bank_sel_r;
    logic [TILES_H-1:0] valid_r [2];
    logic [TILE_PX-1:0] data_r  [2][TILES_H];
    logic               back_s;
    logic               rd_bank_s;

    assign back_s    = ~bank_sel_r;
    // On the swap cycle the read already looks at the freshly filled bank
    assign rd_bank_s = bank_sel_r ^ swap;

    assign chk_valid = valid_r[back_s][chk_idx];
    assign rd_valid  = valid_r[rd_bank_s][rd_idx];
    assign rd_data   = data_r[rd_bank_s][rd_idx];

    // Front-bank select flips on every line swap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_sel_r <= 1'b0;
        end else if (swap) begin
            bank_sel_r <= ~bank_sel_r;
        end
    end

    // Entry valid flags: whole back bank cleared at once, set per ROM write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r[0] <= '0;
            valid_r[1] <= '0;
        end else if (clear) begin
            valid_r[back_s] <= '0;
        end else if (wr_en) begin
            valid_r[back_s][wr_idx] <= 1'b1;
        end
    end

    // Row payload; only meaningful where the valid flag is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[back_s][wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/sprite_line_prefetcher.sv
// Sprite line prefetcher: scans the item list during horizontal blanking,
// fetches the needed sprite rows from the asset ROM into the back line bank,
// and streams the front bank out one pixel per clock.
module sprite_line_prefetcher
    import sprite_pkg::*;
#(
    parameter int NUM_ITEMS = 9,
    parameter int TILES_H   = 16,
    parameter int TILES_V   = 12,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_ITEMS*ITEM_W-1:0] items,
    input  logic [9:0]                  counter_H,
    input  logic [9:0]                  counter_V,
    output logic                        rom_req,
    output logic [3:0]                  rom_charc,
    output logic [1:0]                  rom_dir,
    output logic [2:0]                  rom_row,
    input  logic                        rom_valid,
    input  logic [TILE_PX-1:0]          rom_data,
    output logic                        colour,
    output logic                        busy,
    output logic                        late
);

    localparam int IDX_W = $clog2(TILES_H);

    state_t             state_r, state_n_s;
    logic [3:0]         k_r, k_n_s;
    logic [3:0]         trow_r;
    logic [2:0]         srow_r;
    logic               rom_req_r, busy_r, late_r, colour_r;
    logic [3:0]         rom_charc_r;
    logic [1:0]         rom_dir_r;
    logic [2:0]         rom_row_r;
    logic               latch_s, clear_s, wr_en_s, load_req_s, late_set_s;
    logic               swap_s, hact_s, last_s, hit_s, active_s, colour_n_s;
    logic [9:0]         vn_s;
    logic [ITEM_W-1:0]  item_arr_s [NUM_ITEMS];
    logic [ITEM_W-1:0]  cur_item_s;
    logic [3:0]         cur_id_s;
    logic [1:0]         cur_dir_s;
    logic [7:0]         cur_tile_s;
    logic [7:0]         cur_trow_s;
    logic [IDX_W-1:0]   cur_tcol_s;
    logic               back_valid_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic [2:0]         px_col_s;
    logic               rd_valid_s;
    logic [TILE_PX-1:0] rd_data_s;

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_items
        assign item_arr_s[i] = items[i*ITEM_W +: ITEM_W];
    end

    assign cur_item_s = item_arr_s[k_r];
    assign cur_id_s   = cur_item_s[ITEM_ID_LSB +: 4];
    assign cur_dir_s  = cur_item_s[ITEM_DIR_LSB +: 2];
    assign cur_tile_s = cur_item_s[ITEM_TILE_LSB +: 8];
    assign cur_trow_s = cur_tile_s >> IDX_W;
    assign cur_tcol_s = cur_tile_s[IDX_W-1:0];

    assign vn_s   = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
    assign swap_s = (counter_H == 10'd0);
    assign hact_s = (counter_H == 10'(H_ACTIVE));
    assign last_s = (k_r == 4'(NUM_ITEMS - 1));
    // Off-screen tiles are rejected explicitly so blanking lines stay empty
    assign hit_s  = (cur_id_s != ITEM_UNUSED) && (cur_trow_s == {4'd0, trow_r})
                    && (cur_trow_s < 8'(TILES_V)) && !back_valid_s;

    assign active_s = (counter_H < 10'(H_ACTIVE)) && (counter_V < 10'(V_ACTIVE));
    assign rd_idx_s = IDX_W'(tile_of_pos(counter_H));
    assign px_col_s = src_col_of_pos(counter_H);

    sprite_line_bank #(
        .TILES_H (TILES_H)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .swap      (swap_s),
        .clear     (clear_s),
        .wr_en     (wr_en_s),
        .wr_idx    (cur_tcol_s),
        .wr_data   (rom_data),
        .chk_idx   (cur_tcol_s),
        .chk_valid (back_valid_s),
        .rd_idx    (rd_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_data   (rd_data_s)
    );

    // Next-state, bank control and request capture for the prefetch scan
    always_comb begin
        state_n_s  = state_r;
        k_n_s      = k_r;
        latch_s    = 1'b0;
        clear_s    = 1'b0;
        wr_en_s    = 1'b0;
        load_req_s = 1'b0;
        late_set_s = 1'b0;
        if (swap_s) begin
            // Swapping mid-fetch aborts the scan; partial data is displayed
            if ((state_r != ST_IDLE) && (state_r != ST_DONE)) begin
                late_set_s = 1'b1;
            end else begin
                late_set_s = 1'b0;
            end
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hact_s) begin
                        latch_s   = 1'b1;
                        state_n_s = ST_CLEAR;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    clear_s   = 1'b1;
                    k_n_s     = 4'd0;
                    state_n_s = ST_SCAN;
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        load_req_s = 1'b1;
                        state_n_s  = ST_REQ;
                    end else if (last_s) begin
                        state_n_s = ST_DONE;
                    end else begin
                        k_n_s = k_r + 4'd1;
                    end
                end
                ST_REQ: begin
                    if (rom_valid) begin
                        wr_en_s = 1'b1;
                        if (last_s) begin
                            state_n_s = ST_DONE;
                        end else begin
                            k_n_s     = k_r + 4'd1;
                            state_n_s = ST_SCAN;
                        end
                    end else begin
                        state_n_s = ST_REQ;
                    end
                end
                ST_DONE: begin
                    state_n_s = ST_DONE;
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end
    end

    // Pixel value for the current counters; unfilled tiles show white
    always_comb begin
        colour_n_s = 1'b0;
        if (active_s) begin
            if (rd_valid_s) begin
                colour_n_s = rd_data_s[px_col_s];
            end else begin
                colour_n_s = 1'b1;
            end
        end else begin
            colour_n_s = 1'b0;
        end
    end

    // State, scan context and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            k_r         <= 4'd0;
            trow_r      <= 4'd0;
            srow_r      <= 3'd0;
            rom_req_r   <= 1'b0;
            rom_charc_r <= 4'd0;
            rom_dir_r   <= 2'd0;
            rom_row_r   <= 3'd0;
            busy_r      <= 1'b0;
            late_r      <= 1'b0;
            colour_r    <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            k_r       <= k_n_s;
            rom_req_r <= (state_n_s == ST_REQ);
            busy_r    <= (state_n_s == ST_CLEAR) || (state_n_s == ST_SCAN)
                         || (state_n_s == ST_REQ);
            colour_r  <= colour_n_s;
            if (latch_s) begin
                trow_r <= tile_of_pos(vn_s);
                srow_r <= src_col_of_pos(vn_s);
            end
            if (load_req_s) begin
                rom_charc_r <= cur_id_s;
                rom_dir_r   <= cur_dir_s;
                rom_row_r   <= srow_r;
            end
            if (late_set_s) begin
                late_r <= 1'b1;
            end
        end
    end

    assign rom_req   = rom_req_r;
    assign rom_charc = rom_charc_r;
    assign rom_dir   = rom_dir_r;
    assign rom_row   = rom_row_r;
    assign busy      = busy_r;
    assign late      = late_r;
    assign colour    = colour_r;

endmodule

// File: tb/tb_sprite_line_prefetcher.sv
// Scoreboard bench for sprite_line_prefetcher: stimulus pushes expected pixels
// and ROM requests into queues, independent monitors pop and compare them.
module tb_sprite_line_prefetcher;

    localparam int NI = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic [NI*14-1:0] items;
    logic [9:0]       counter_H, counter_V;
    logic             rom_req;
    logic [3:0]       rom_charc;
    logic [1:0]       rom_dir;
    logic [2:0]       rom_row;
    logic             rom_valid, rom_valid_auto, rom_valid_man;
    logic [7:0]       rom_word;
    logic             colour, busy, late;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rom_lat = 2;
    int req_count = 0;

    typedef struct {
        int   due;
        logic exp;
        int   h;
        int   v;
    } pix_t;
    pix_t pix_q[$];

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] dir;
        logic [2:0] row;
    } req_t;
    req_t req_q[$];

    // Hand-set expected front line for the line being displayed
    logic [7:0] exp_d [16];
    logic       exp_v [16];

    assign rom_valid = rom_valid_auto | rom_valid_man;

    always #5 clk = ~clk;

    sprite_line_prefetcher dut (
        .clk       (clk),
        .reset     (reset),
        .items     (items),
        .counter_H (counter_H),
        .counter_V (counter_V),
        .rom_req   (rom_req),
        .rom_charc (rom_charc),
        .rom_dir   (rom_dir),
        .rom_row   (rom_row),
        .rom_valid (rom_valid),
        .rom_data  (rom_word),
        .colour    (colour),
        .busy      (busy),
        .late      (late)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] mk_item(input logic [3:0] id, input logic [1:0] dir,
                                             input logic [7:0] tile);
        return {id, dir, tile};
    endfunction

    task automatic set_item(input int k, input logic [13:0] it);
        items[k*14 +: 14] = it;
    endtask

    task automatic all_unused();
        for (int k = 0; k < NI; k++) items[k*14 +: 14] = {4'hF, 2'b00, 8'd0};
    endtask

    task automatic clear_front();
        for (int e = 0; e < 16; e++) begin
            exp_v[e] = 1'b0;
            exp_d[e] = 8'd0;
        end
    endtask

    task automatic set_front(input int e, input logic [7:0] d);
        exp_v[e] = 1'b1;
        exp_d[e] = d;
    endtask

    function automatic logic exp_pix(input int h, input int v);
        int e;
        int c;
        logic [7:0] d;
        if (h >= 640 || v >= 480) return 1'b0;
        e = h / 40;
        c = (h % 40) / 5;
        d = exp_d[e];
        if (exp_v[e]) return d[c];
        return 1'b1;
    endfunction

    task automatic step(input int h, input int v, input bit chk);
        @(posedge clk);
        #1;
        counter_H = 10'(h);
        counter_V = 10'(v);
        if (chk) pix_q.push_back('{cyc + 1, exp_pix(h, v), h, v});
    endtask

    task automatic drive_line(input int v, input int h0, input int h1, input bit chk);
        for (int h = h0; h <= h1; h++) step(h, v, chk);
    endtask

    // Cycle stamp used to line up expected pixels with the one-cycle readout
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ROM model: answers a held request after rom_lat cycles
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        rom_valid_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rom_valid_auto = 1'b0;
            if (rom_req === 1'b1 && reset === 1'b1) begin
                if (lat_cnt >= rom_lat) begin
                    rom_valid_auto = 1'b1;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Pixel monitor
    initial begin
        pix_t p;
        forever begin
            @(negedge clk);
            while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
                p = pix_q.pop_front();
                checks++;
                if (colour !== p.exp) begin
                    errors++;
                    $display("FAIL pixel h=%0d v=%0d: colour %0b expected %0b", p.h, p.v, colour, p.exp);
                end
            end
        end
    end

    // ROM request monitor
    initial begin
        bit   seen;
        req_t r;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rom_req === 1'b1 && !seen) begin
                seen = 1'b1;
                req_count++;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got id %0h dir %0h row %0d, expected none",
                             rom_charc, rom_dir, rom_row);
                end else begin
                    r = req_q.pop_front();
                    check("rom_req_fields", 32'({rom_charc, rom_dir, rom_row}), 32'(r));
                end
            end else if (rom_req !== 1'b1) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int n0;
        reset = 1'b0;
        counter_H = 10'd0;
        counter_V = 10'd0;
        rom_valid_man = 1'b0;
        rom_word = 8'd0;
        all_unused();
        clear_front();
        repeat (3) @(posedge clk);
        #1;
        check("reset_colour", 32'(colour), 32'd0);
        check("reset_rom_req", 32'(rom_req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_late", 32'(late), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset while a request is outstanding, then a stray rom_valid
        set_item(0, mk_item(4'h3, 2'b01, 8'd18));
        rom_lat = 1000;
        rom_word = 8'h00;
        req_q.push_back({4'h3, 2'b01, 3'd0});
        drive_line(39, 600, 660, 1'b0);
        check("t1_req_held", 32'(rom_req), 32'd1);
        @(posedge clk);
        #1;
        counter_H = 10'd661;
        reset = 1'b0;
        #1;
        check("t1_req_drop", 32'(rom_req), 32'd0);
        @(posedge clk);
        #1;
        counter_H = 10'd662;
        reset = 1'b1;
        @(posedge clk);
        #1;
        counter_H = 10'd663;
        rom_valid_man = 1'b1;
        @(posedge clk);
        #1;
        counter_H = 10'd664;
        rom_valid_man = 1'b0;
        drive_line(39, 665, 799, 1'b0);
        check("t1_req_after", 32'(rom_req), 32'd0);
        check("t1_late", 32'(late), 32'd0);
        all_unused();
        clear_front();
        drive_line(40, 0, 799, 1'b1);

        // Single sprite row on tile 18 (row 1, column 2)
        rom_lat = 2;
        set_item(0, mk_item(4'h3, 2'b01, 8'd18));
        rom_word = 8'b0000_0101;
        req_q.push_back({4'h3, 2'b01, 3'd0});
        drive_line(39, 0, 799, 1'b0);
        check("t2_busy_done", 32'(busy), 32'd0);
        all_unused();
        clear_front();
        set_front(2, 8'h05);
        drive_line(40, 0, 799, 1'b1);

        // Two items sharing tile 20: lower index wins, one request only
        set_item(2, mk_item(4'h5, 2'b10, 8'd20));
        set_item(5, mk_item(4'h7, 2'b00, 8'd20));
        rom_word = 8'hF0;
        req_q.push_back({4'h5, 2'b10, 3'd2});
        drive_line(49, 0, 799, 1'b0);
        all_unused();
        clear_front();
        set_front(4, 8'hF0);
        drive_line(50, 0, 799, 1'b1);

        // Frame wrap: counter_V=524 prefetches line 0
        set_item(0, mk_item(4'h2, 2'b11, 8'd3));
        rom_word = 8'hAA;
        req_q.push_back({4'h2, 2'b11, 3'd0});
        drive_line(524, 0, 799, 1'b0);
        all_unused();
        clear_front();
        set_front(3, 8'hAA);
        drive_line(0, 0, 799, 1'b1);

        // Next line 480 is blanking: off-screen tiles must not fetch
        set_item(0, mk_item(4'h1, 2'b00, 8'd192));
        set_item(1, mk_item(4'h6, 2'b01, 8'd200));
        set_item(2, mk_item(4'h4, 2'b00, 8'd0));
        n0 = req_count;
        drive_line(479, 0, 799, 1'b0);
        all_unused();
        clear_front();
        drive_line(480, 0, 799, 1'b1);
        check("t6_no_req", 32'(req_count - n0), 32'd0);

        // All items unused: no requests, white active area
        n0 = req_count;
        drive_line(100, 0, 799, 1'b0);
        clear_front();
        drive_line(101, 0, 799, 1'b1);
        check("t4_no_req", 32'(req_count - n0), 32'd0);

        // ROM stall past the line wrap: late sticks, scan aborted
        set_item(0, mk_item(4'h9, 2'b00, 8'd18));
        rom_lat = 200;
        rom_word = 8'h00;
        req_q.push_back({4'h9, 2'b00, 3'd0});
        drive_line(39, 0, 799, 1'b0);
        check("t5_late_before", 32'(late), 32'd0);
        check("t5_busy_stall", 32'(busy), 32'd1);
        check("t5_req_stall", 32'(rom_req), 32'd1);
        all_unused();
        clear_front();
        drive_line(40, 0, 4, 1'b1);
        check("t5_late_set", 32'(late), 32'd1);
        check("t5_req_abort", 32'(rom_req), 32'd0);
        check("t5_busy_abort", 32'(busy), 32'd0);
        drive_line(40, 5, 644, 1'b1);
        check("t5_rescan_busy", 32'(busy), 32'd1);
        drive_line(40, 645, 799, 1'b1);
        drive_line(41, 0, 3, 1'b0);
        check("t5_late_sticky", 32'(late), 32'd1);

        repeat (3) @(posedge clk);
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
